// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-buffer constants, types and helpers.
package uart_rx_fifo_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int UART_OVS          = 16;
   localparam int UART_BITS_PER_CHR = 10;
   localparam int UART_TO_CHARS     = 4;
   localparam int UART_TO_TICKS_DEF = UART_OVS * UART_BITS_PER_CHR * UART_TO_CHARS;

   typedef struct packed {
      logic wr;
      logic rd;
   } fifo_op_t;

   // Timeout counter holds 0..ticks-1 and is never narrower than 10 bits.
   function automatic int to_cnt_width(input int ticks);
      int w;
      w = $clog2(ticks);
      return (w < 10) ? 10 : w;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and register-side signals of the UART receive buffer.
interface uart_rx_fifo_if
   import uart_rx_fifo_pkg::*;
#(
   parameter int AW = 4
);
   logic                   b_tick;
   logic                   rx_done;
   logic [UART_DATA_W-1:0] rx_data;
   logic                   rd_en;
   logic                   clr_ovr;
   logic [UART_DATA_W-1:0] rd_data;
   logic                   empty;
   logic                   full;
   logic [AW:0]            count;
   logic                   overrun;
   logic                   irq;

   modport master (
      output b_tick, rx_done, rx_data, rd_en, clr_ovr,
      input  rd_data, empty, full, count, overrun, irq
   );

   modport slave (
      input  b_tick, rx_done, rx_data, rd_en, clr_ovr,
      output rd_data, empty, full, count, overrun, irq
   );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
   import uart_rx_fifo_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [UART_DATA_W-1:0] wdata,
   input  logic [AW-1:0]          raddr,
   output logic [UART_DATA_W-1:0] rdata
);
   logic [UART_DATA_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT FIFO with sticky overrun, fill-level irq and character timeout.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int AW       = 4,
   parameter int IRQ_THR  = 1,
   parameter int TO_TICKS = UART_TO_TICKS_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   uart_rx_fifo_if.slave  bus
);
   localparam int            DEPTH   = 2**AW;
   localparam int            TW      = to_cnt_width(TO_TICKS);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   IRQ_C   = (AW+1)'(IRQ_THR);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS - 1);

   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            count;
   logic [AW:0]            count_nxt;
   logic                   overrun;
   logic                   to_flag;
   logic [TW-1:0]          to_cnt;
   logic                   empty;
   logic                   full;
   logic                   ovr_set;
   logic                   to_rst;
   logic                   to_hit;
   fifo_op_t               op;
   logic [UART_DATA_W-1:0] mem_rdata;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a write when rd_en is high.
   assign op.wr   = bus.rx_done & (~full | bus.rd_en);
   assign op.rd   = bus.rd_en & ~empty;
   assign ovr_set = bus.rx_done & full & ~bus.rd_en;

   always_comb begin
      count_nxt = count;
      unique case ({op.wr, op.rd})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   assign to_rst = op.wr | op.rd | empty;
   assign to_hit = ~to_rst & bus.b_tick & (to_cnt == TO_LAST);

   uart_fifo_mem #(.AW(AW)) u_mem (
      .clk   (clk),
      .we    (op.wr),
      .waddr (wr_ptr),
      .wdata (bus.rx_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         to_flag <= 1'b0;
         to_cnt  <= '0;
      end else begin
         if (op.wr) wr_ptr <= wr_ptr + 1'b1;
         if (op.rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;

         if (ovr_set)          overrun <= 1'b1;
         else if (bus.clr_ovr) overrun <= 1'b0;

         if (to_rst)                               to_cnt <= '0;
         else if (bus.b_tick && to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

         if (to_hit)                                          to_flag <= 1'b1;
         else if (bus.clr_ovr || op.wr || count_nxt == '0)    to_flag <= 1'b0;
      end
   end

   // Memory is unreset; mask the head while empty so rd_data is never X.
   assign bus.rd_data = empty ? '0 : mem_rdata;
   assign bus.empty   = empty;
   assign bus.full    = full;
   assign bus.count   = count;
   assign bus.overrun = overrun;
   assign bus.irq     = (count >= IRQ_C) | to_flag;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: writes queue expected bytes, a negedge monitor checks pops.
module tb_uart_rx_fifo;
   logic clk;
   logic resetn;

   uart_rx_fifo_if #(.AW(4)) bus ();

   uart_rx_fifo #(.AW(4), .IRQ_THR(4), .TO_TICKS(640)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // A pop is taken at the coming edge whenever rd_en is high on a non-empty FIFO.
   always @(negedge clk) begin
      if (resetn && bus.rd_en && !bus.empty) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: got %0h expected nothing (queue empty)", bus.rd_data);
         end else begin
            if (bus.rd_data !== exp_q[0]) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h", bus.rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] b);
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      exp_q.push_back(b);
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic write_drop(input logic [7:0] b);
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic write_and_pop(input logic [7:0] b);
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      bus.rd_en   = 1'b1;
      exp_q.push_back(b);
      tick();
      bus.rx_done = 1'b0;
      bus.rd_en   = 1'b0;
   endtask

   initial begin
      resetn      = 1'b0;
      bus.b_tick  = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_en   = 1'b0;
      bus.clr_ovr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_empty",   32'(bus.empty),   32'd1);
      check("reset_full",    32'(bus.full),    32'd0);
      check("reset_count",   32'(bus.count),   32'd0);
      check("reset_irq",     32'(bus.irq),     32'd0);
      check("reset_overrun", 32'(bus.overrun), 32'd0);
      check("reset_rd_data", 32'(bus.rd_data), 32'h00);
      resetn = 1'b1;
      tick();

      // 1: three bytes in, three out
      write(8'h41); write(8'h42); write(8'h43);
      check("t1_count",   32'(bus.count),   32'd3);
      check("t1_rd_data", 32'(bus.rd_data), 32'h41);
      check("t1_irq",     32'(bus.irq),     32'd0);
      repeat (3) pop();
      check("t1_empty", 32'(bus.empty), 32'd1);

      // 2: fill, overrun on 17th, clear
      for (int i = 0; i < 16; i++) write(8'(8'h10 + i));
      check("t2_full",  32'(bus.full),  32'd1);
      check("t2_count", 32'(bus.count), 32'd16);
      check("t2_irq",   32'(bus.irq),   32'd1);
      write_drop(8'hFF);
      check("t2_overrun", 32'(bus.overrun), 32'd1);
      check("t2_count_hold", 32'(bus.count), 32'd16);
      pop();
      bus.clr_ovr = 1'b1;
      tick();
      bus.clr_ovr = 1'b0;
      check("t2_overrun_clr", 32'(bus.overrun), 32'd0);

      // 3: simultaneous write and pop while full
      write(8'h20);
      check("t3_full", 32'(bus.full), 32'd1);
      write_and_pop(8'hA5);
      check("t3_overrun", 32'(bus.overrun), 32'd0);
      check("t3_count",   32'(bus.count),   32'd16);
      repeat (16) pop();
      check("t3_empty", 32'(bus.empty), 32'd1);

      // 4: simultaneous write and pop while empty
      write_and_pop(8'h5A);
      check("t4_count",   32'(bus.count),   32'd1);
      check("t4_rd_data", 32'(bus.rd_data), 32'h5A);
      pop();

      // 5: character timeout
      write(8'h77);
      bus.b_tick = 1'b1;
      repeat (639) tick();
      bus.b_tick = 1'b0;
      check("t5_irq_639", 32'(bus.irq), 32'd0);
      bus.b_tick = 1'b1;
      tick();
      bus.b_tick = 1'b0;
      check("t5_irq_640", 32'(bus.irq), 32'd1);
      pop();
      check("t5_irq_empty", 32'(bus.irq), 32'd0);

      // 6: pointer wrap, then async reset mid-stream
      for (int i = 0; i < 40; i++) begin
         write(8'(8'h80 + i));
         pop();
      end
      check("t6_overrun", 32'(bus.overrun), 32'd0);
      check("t6_empty",   32'(bus.empty),   32'd1);
      for (int i = 0; i < 5; i++) write(8'(8'hC0 + i));
      check("t6_pre_irq",   32'(bus.irq),   32'd1);
      check("t6_pre_count", 32'(bus.count), 32'd5);
      #1;
      resetn = 1'b0;
      #1;
      check("t6_rst_empty", 32'(bus.empty), 32'd1);
      check("t6_rst_count", 32'(bus.count), 32'd0);
      check("t6_rst_irq",   32'(bus.irq),   32'd0);
      exp_q.delete();
      tick();
      resetn = 1'b1;
      tick();
      write(8'h3C);
      check("t6_post_rd_data", 32'(bus.rd_data), 32'h3C);
      pop();
      tick();
      check("final_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
